enc_dec_slave_if: RTL and testbench

- Serial-link slave that terminates the chip-select/Mosi/Miso link driven by the host-side master.
- Deserializes the incoming {message, key} frame and hands it to the AES encrypt/decrypt core with a start pulse.
- Waits for the core's result, then serializes the result back to the master on Miso.
- Sits between the serial link and the AES core on the device side.

---
 rtl/enc_dec_slave_if.sv | 174 +++++++++++++++++
 tb/tb_enc_dec_slave_if.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_dec_slave_if.sv
// enc_dec_slave_if
//   Device-side slave of the chip-select / Mosi / Miso serial link.
//   It receives a {message, key} frame MSB first and presents it to the AES
//   core with a one-cycle start pulse. It then waits for the core's result
//   and shifts that result back to the master on Miso, MSB first, after a
//   single turnaround cycle.
//
// Ports
//   in_clk      : link/system clock, all logic on posedge
//   rst         : asynchronous active-high reset
//   cs_enc_dec  : chip select, active low (low = frame in progress)
//   Mosi        : serial data from master, MSB first
//   Miso        : serial result to master, MSB first
//   msg_out     : received message block (MSG_W bits)
//   key_out     : received key (KEY_W bits)
//   core_start  : one-cycle start pulse to the core
//   core_done   : core result valid (level or pulse), sampled only in WAIT
//   core_result : core output block (MSG_W bits)
//   data_done   : one-cycle strobe after the last result bit has been sent
//   busy        : high in every state except IDLE
//
// Build option
//   MISO_TRISTATE_EN : when defined, Miso is high-Z in every state except
//                      TURN and SEND. The default build drives 0 instead.
//
// state | meaning
// IDLE  | waiting for chip select low; the first frame bit is captured here
// RECV  | shifting in the remaining frame bits
// START | core_start pulse
// WAIT  | waiting for core_done
// TURN  | one turnaround cycle, Miso = 0
// SEND  | shifting the result out on Miso
// DONE  | result sent; hold here until chip select goes high

module enc_dec_slave_if #(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              cs_enc_dec,
  input  logic              Mosi,
  output logic              Miso,
  output logic [32*nb-1:0]  msg_out,
  output logic [32*nk-1:0]  key_out,
  output logic              core_start,
  input  logic              core_done,
  input  logic [32*nb-1:0]  core_result,
  output logic              data_done,
  output logic              busy
);

  localparam int MSG_W = 32 * nb;
  localparam int KEY_W = 32 * nk;
  localparam int F     = MSG_W + KEY_W;
  localparam int CW    = $clog2(F + 1);

  localparam logic [CW-1:0] LAST_RX = CW'(F - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(MSG_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] TURN  = 3'd4;
  localparam logic [2:0] SEND  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  // nr is consumed by the core only; it is range-checked here so that a
  // misconfigured instance fails at elaboration.
  if (nk < 1 || nb < 1 || nr < 1) begin : g_param_check
    $error("enc_dec_slave_if: nk, nb and nr must all be positive");
  end

  logic [2:0]       state;
  logic [CW-1:0]    count;
  // Only F-1 bits of history are stored: the last frame bit arrives on Mosi
  // in the same cycle the frame is registered.
  logic [F-2:0]     sr;
  logic [MSG_W-1:0] piso;
  logic [F-1:0]     frame;

  assign frame = {sr, Mosi};

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      sr        <= '0;
      piso      <= '0;
      msg_out   <= '0;
      key_out   <= '0;
      data_done <= 1'b0;
    end else begin
      data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_enc_dec) begin
            sr    <= frame[F-2:0];
            count <= CW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (cs_enc_dec) begin
            state <= IDLE;
          end else begin
            sr    <= frame[F-2:0];
            count <= count + CW'(1);
            if (count == LAST_RX) begin
              msg_out <= frame[F-1:KEY_W];
              key_out <= frame[KEY_W-1:0];
              state   <= START;
            end
          end
        end
        START: begin
          state <= cs_enc_dec ? IDLE : WAIT;
        end
        WAIT: begin
          if (cs_enc_dec) begin
            state <= IDLE;
          end else if (core_done) begin
            piso  <= core_result;
            state <= TURN;
          end
        end
        TURN: begin
          if (cs_enc_dec) begin
            state <= IDLE;
          end else begin
            count <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (cs_enc_dec) begin
            state <= IDLE;
          end else begin
            piso  <= {piso[MSG_W-2:0], 1'b0};
            count <= count + CW'(1);
            if (count == LAST_TX) begin
              state     <= DONE;
              data_done <= 1'b1;
            end
          end
        end
        DONE: begin
          // A chip select that is still low must not restart a frame.
          if (cs_enc_dec) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_start = (state == START);
  assign busy       = (state != IDLE);

`ifdef MISO_TRISTATE_EN
  always_comb begin
    Miso = 1'bz;
    if (state == TURN)      Miso = 1'b0;
    else if (state == SEND) Miso = piso[MSG_W-1];
  end
`else
  always_comb begin
    Miso = 1'b0;
    if (state == SEND) Miso = piso[MSG_W-1];
  end
`endif

endmodule

// File: tb/tb_enc_dec_slave_if.sv
module tb_enc_dec_slave_if;

  localparam int MW = 128;
  localparam int KW = 256;
  localparam int F  = MW + KW;

  localparam logic [MW-1:0] NOM_MSG = 128'h00112233445566778899aabbccddeeff;
  localparam logic [KW-1:0] NOM_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [MW-1:0] NOM_RES = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          mosi;
  logic          miso;
  logic [MW-1:0] msg_out;
  logic [KW-1:0] key_out;
  logic          core_start;
  logic          core_done;
  logic [MW-1:0] core_result;
  logic          data_done;
  logic          busy;

  enc_dec_slave_if #(.nk(8), .nb(4), .nr(14)) dut (
    .in_clk      (clk),
    .rst         (rst),
    .cs_enc_dec  (cs),
    .Mosi        (mosi),
    .Miso        (miso),
    .msg_out     (msg_out),
    .key_out     (key_out),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .data_done   (data_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] msg;
    logic [KW-1:0] key;
    logic [MW-1:0] res;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int cs_cnt   = 0;
  int exp_cs   = 0;
  int dd_cnt   = 0;
  int exp_dd   = 0;
  logic [MW-1:0] last_msg = '0;
  logic [KW-1:0] last_key = '0;

  int  core_delay    = 20;
  bit  spur_on_start = 1'b0;
  bit  spur_idle     = 1'b0;

  // Stand-in for the AES core: the published AES-256 vector for the nominal
  // frame, an arbitrary but fixed mixing of msg and key for anything else.
  function automatic logic [MW-1:0] ref_result(input logic [MW-1:0] m, input logic [KW-1:0] k);
    if (m == NOM_MSG && k == NOM_KEY) return NOM_RES;
    return m ^ k[255:128] ^ {k[63:0], k[127:64]};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [F-1:0] act, input logic [F-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Core model
  int            cm_cnt;
  bit            cm_pend;
  logic [MW-1:0] cm_res;
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    cm_pend     = 1'b0;
    cm_cnt      = 0;
    cm_res      = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      cm_pend   = 1'b0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (cm_pend) begin
        if (cm_cnt <= 1) begin
          core_done   = 1'b1;
          core_result = cm_res;
          cm_pend     = 1'b0;
        end else begin
          cm_cnt--;
        end
      end
      if (core_start) begin
        cm_pend = 1'b1;
        cm_cnt  = core_delay;
        cm_res  = ref_result(msg_out, key_out);
        if (spur_on_start) begin
          core_done   = 1'b1;
          core_result = ~cm_res;
        end
      end
      if (spur_idle) begin
        core_done   = 1'b1;
        core_result = '1;
        spur_idle   = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  logic [MW:0] win = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_start) begin
        cs_cnt++;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_core_start", F'(1), F'(0));
        end else begin
          chk(msg_out === q[0].msg, "msg_out", F'(msg_out), F'(q[0].msg));
          chk(key_out === q[0].key, "key_out", F'(key_out), F'(q[0].key));
        end
      end
      if (data_done) begin
        dd_cnt++;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_data_done", F'(1), F'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(win === {1'b0, e.res}, "miso_stream", F'(win), F'({1'b0, e.res}));
        end
      end
      if (busy) win = {win[MW-1:0], miso};
      else chk(miso === IDLE_MISO, "miso_idle", F'(miso), F'(IDLE_MISO));
    end
  end

  task automatic drive_bits(input logic [F-1:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cs   = 1'b0;
      mosi = frame[F-1-i];
    end
  endtask

  task automatic send_frame(input logic [MW-1:0] m, input logic [KW-1:0] k);
    exp_t e;
    e.msg = m;
    e.key = k;
    e.res = ref_result(m, k);
    q.push_back(e);
    exp_cs++;
    drive_bits({m, k}, F);
    last_msg = m;
    last_key = k;
  endtask

  task automatic finish_frame(input int hold);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      mosi = 1'($urandom);
      seen = data_done;
      n++;
    end
    chk(seen, "data_done_timeout", F'(seen), F'(1));
    exp_dd++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      mosi = 1'($urandom);
    end
    if (hold > 0) chk(busy === 1'b1, "done_hold_busy", F'(busy), F'(1));
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    chk(busy === 1'b0, "idle_after_cs", F'(busy), F'(0));
  endtask

  function automatic logic [MW-1:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
    #3;
    chk(msg_out === '0, "reset_msg_out", F'(msg_out), F'(0));
    chk(key_out === '0, "reset_key_out", F'(key_out), F'(0));
    chk({busy, core_start, data_done} === 3'b000, "reset_flags",
        F'({busy, core_start, data_done}), F'(0));
    chk(miso === IDLE_MISO, "reset_miso", F'(miso), F'(IDLE_MISO));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal AES-256 frame
    core_delay = 20;
    send_frame(NOM_MSG, NOM_KEY);
    finish_frame(0);

    // Abort mid-RECV after 200 bits
    drive_bits({rand_msg(), rand_key()}, 200);
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    chk(busy === 1'b0, "abort_busy", F'(busy), F'(0));
    chk(msg_out === last_msg, "abort_msg_hold", F'(msg_out), F'(last_msg));
    chk(key_out === last_key, "abort_key_hold", F'(key_out), F'(last_key));
    repeat (3) @(negedge clk);

    // DONE hold with chip select low for 50 cycles
    core_delay = 7;
    send_frame(rand_msg(), rand_key());
    finish_frame(50);

    // Reset while the core is still busy
    core_delay = 200;
    send_frame(rand_msg(), rand_key());
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(msg_out === '0, "midreset_msg_out", F'(msg_out), F'(0));
    chk(key_out === '0, "midreset_key_out", F'(key_out), F'(0));
    chk({busy, core_start, data_done} === 3'b000, "midreset_flags",
        F'({busy, core_start, data_done}), F'(0));
    chk(miso === IDLE_MISO, "midreset_miso", F'(miso), F'(IDLE_MISO));
    q.delete();
    cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    core_delay = 10;
    send_frame(NOM_MSG, NOM_KEY);
    finish_frame(0);

    // Spurious core_done in IDLE and on the START cycle
    spur_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk(busy === 1'b0, "spur_idle_busy", F'(busy), F'(0));
    spur_on_start = 1'b1;
    core_delay    = 15;
    send_frame(rand_msg(), rand_key());
    finish_frame(0);
    spur_on_start = 1'b0;

    // Back-to-back frames, two cs-high cycles between them
    for (int f = 0; f < 2; f++) begin
      core_delay = 5 + f;
      send_frame(rand_msg(), rand_key());
      finish_frame(0);
    end

    // Randomized frames
    for (int f = 0; f < 3; f++) begin
      core_delay = $urandom_range(1, 40);
      send_frame(rand_msg(), rand_key());
      finish_frame($urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk(cs_cnt == exp_cs, "core_start_count", F'(cs_cnt), F'(exp_cs));
    chk(dd_cnt == exp_dd, "data_done_count", F'(dd_cnt), F'(exp_dd));
    chk(q.size() == 0, "scoreboard_empty", F'(q.size()), F'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
